// File: rtl/serdes_rx_pkg.sv
// rtl/serdes_rx_pkg.sv - shared state encoding and thresholds for the serdes receive framer
package serdes_rx_pkg;

  typedef enum logic [2:0] {
    CHECK   = 3'd0,
    SLIP    = 3'd1,
    WAIT    = 3'd2,
    HUNT    = 3'd3,
    LEN     = 3'd4,
    PAYLOAD = 3'd5,
    CSUM    = 3'd6
  } state_t;

  localparam int BAD_LIMIT  = 4;
  localparam int SLIP_LIMIT = 8;

endpackage

// File: rtl/serdes_rx_fifo.sv
// rtl/serdes_rx_fifo.sv - first-word fall-through payload FIFO with a registered head word
module serdes_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             clkdiv,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = head;

  always_ff @(posedge clkdiv) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // head is a register so dout resets to zero and holds its value once the FIFO drains
  always_ff @(posedge clkdiv or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop_ok) begin
        if (count > CW'(1)) begin
          head <= mem[rd_ptr + 1'b1];
        end else if (push_ok) begin
          head <= din;
        end
      end else if (empty && push_ok) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/serdes_rx_framer.sv
// rtl/serdes_rx_framer.sv - bitslip word aligner and SOF/length/payload/checksum frame extractor
module serdes_rx_framer
  import serdes_rx_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = 8'h0E,
  parameter int         LOCK_COUNT    = 4,
  parameter int         SLIP_WAIT     = 3,
  parameter logic [7:0] SOF           = 8'hA5,
  parameter int         FIFO_DEPTH    = 16
) (
  input  logic       clkdiv,
  input  logic       rst_n,
  input  logic [7:0] q,
  output logic       bitslip,
  output logic       locked,
  output logic       align_fail,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [7:0] WAIT_LAST = 8'(SLIP_WAIT - 1);
  localparam logic [2:0] BAD_LAST  = 3'(BAD_LIMIT - 1);
  localparam logic [2:0] SLIP_LAST = 3'(SLIP_LIMIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] match_cnt;
  logic [2:0] slip_cnt;
  logic [7:0] wait_cnt;
  logic [2:0] bad_cnt;
  logic [7:0] len;
  logic [7:0] sum;
  logic [7:0] byte_cnt;
  logic       is_train;
  logic       is_sof;
  logic       last_byte;
  logic       push;
  logic       fifo_full;
  logic       fifo_empty;
  logic [8:0] fifo_dout;

  assign is_train  = (q == TRAIN_PATTERN);
  assign is_sof    = (q == SOF);
  assign last_byte = (byte_cnt == len - 8'd1);

  always_ff @(posedge clkdiv or negedge rst_n) begin
    if (!rst_n) begin
      state <= CHECK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CHECK: begin
        if (!is_train) begin
          state_nxt = SLIP;
        end else if (match_cnt == LOCK_LAST) begin
          state_nxt = HUNT;
        end
      end
      SLIP:    state_nxt = WAIT;
      WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = CHECK;
        end
      end
      HUNT: begin
        if (is_sof) begin
          state_nxt = LEN;
        end else if (!is_train && bad_cnt == BAD_LAST) begin
          state_nxt = CHECK;
        end
      end
      LEN:     state_nxt = (q == 8'h00) ? HUNT : PAYLOAD;
      PAYLOAD: begin
        if (last_byte) begin
          state_nxt = CSUM;
        end
      end
      CSUM:    state_nxt = HUNT;
      default: state_nxt = CHECK;
    endcase
  end

  always_comb begin
    bitslip = (state == SLIP);
    locked  = (state == HUNT) || (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    push    = (state == PAYLOAD);
  end

  // counters, checksum and the registered one-cycle pulses
  always_ff @(posedge clkdiv or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt  <= '0;
      slip_cnt   <= '0;
      wait_cnt   <= '0;
      bad_cnt    <= '0;
      len        <= '0;
      sum        <= '0;
      byte_cnt   <= '0;
      align_fail <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      align_fail <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        CHECK: begin
          match_cnt <= is_train ? match_cnt + 4'd1 : 4'd0;
        end
        SLIP: begin
          slip_cnt   <= slip_cnt + 3'd1;
          align_fail <= (slip_cnt == SLIP_LAST);
        end
        WAIT: begin
          wait_cnt <= (wait_cnt == WAIT_LAST) ? 8'd0 : wait_cnt + 8'd1;
        end
        HUNT: begin
          if (is_train || is_sof) begin
            bad_cnt <= '0;
          end else if (bad_cnt == BAD_LAST) begin
            bad_cnt   <= '0;
            match_cnt <= '0;
          end else begin
            bad_cnt <= bad_cnt + 3'd1;
          end
        end
        LEN: begin
          len       <= q;
          sum       <= q;
          byte_cnt  <= '0;
          frame_err <= (q == 8'h00);
        end
        PAYLOAD: begin
          sum      <= sum + q;
          byte_cnt <= byte_cnt + 8'd1;
        end
        CSUM: begin
          frame_err <= (q != sum);
        end
        default: begin
        end
      endcase
      // a full FIFO only accepts the byte when the consumer pops in the same cycle
      if (push && fifo_full && !m_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  serdes_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clkdiv (clkdiv),
    .rst_n  (rst_n),
    .push   (push),
    .din    ({last_byte, q}),
    .full   (fifo_full),
    .pop    (m_ready),
    .dout   (fifo_dout),
    .empty  (fifo_empty)
  );

  assign m_data  = fifo_dout[7:0];
  assign m_last  = fifo_dout[8];
  assign m_valid = !fifo_empty;

endmodule
